// File: rtl/if_id_skid_reg_if.sv
// IF->ID handshake bundle: upstream offer channel plus downstream presentation channel.
// The block under design takes the slave view; the fetch/decode side takes the master view.
interface if_id_skid_reg_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/if_id_skid_reg.sv
// Two-entry IF/ID pipeline register (main + skid) with freeze, flush and registered outputs.
// Optional stall statistics counter enabled by defining IF_ID_STALL_STATS_EN.
module if_id_skid_reg #(
  parameter int                  PC_W      = 32,
  parameter int                  INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = '0,
  parameter int                  CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             flush,
  if_id_skid_reg_if.slave  bus,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e             state_q;
  logic [PC_W-1:0]    main_pc_q;
  logic [INSTR_W-1:0] main_instr_q;
  logic [PC_W-1:0]    skid_pc_q;
  logic [INSTR_W-1:0] skid_instr_q;

  logic in_ready_w;
  logic out_valid_w;
  logic accept;
  logic consume;

  assign out_valid_w = (state_q != S_EMPTY);
  assign in_ready_w  = (state_q != S_TWO) && !freeze;
  assign accept      = bus.in_valid && in_ready_w;
  assign consume     = out_valid_w && bus.out_ready && !freeze;

  // Main entry is cleared to the bubble value whenever it empties, so the
  // outputs can be wired straight from the registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_EMPTY;
      main_pc_q    <= '0;
      main_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
    end else if (flush) begin
      state_q      <= S_EMPTY;
      main_pc_q    <= '0;
      main_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
    end else if (!freeze) begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            main_pc_q    <= bus.in_pc;
            main_instr_q <= bus.in_instr;
            state_q      <= S_ONE;
          end
        end
        S_ONE: begin
          if (accept && consume) begin
            main_pc_q    <= bus.in_pc;
            main_instr_q <= bus.in_instr;
          end else if (accept) begin
            skid_pc_q    <= bus.in_pc;
            skid_instr_q <= bus.in_instr;
            state_q      <= S_TWO;
          end else if (consume) begin
            main_pc_q    <= '0;
            main_instr_q <= NOP_INSTR;
            state_q      <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (consume) begin
            main_pc_q    <= skid_pc_q;
            main_instr_q <= skid_instr_q;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
            state_q      <= S_ONE;
          end
        end
        default: begin
          state_q      <= S_EMPTY;
          main_pc_q    <= '0;
          main_instr_q <= NOP_INSTR;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_pc    = main_pc_q;
  assign bus.out_instr = main_instr_q;

`ifdef IF_ID_STALL_STATS_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] stall_d;

  // A presented entry that is not taken (back-pressure or freeze) is a stall cycle.
  always_comb begin
    stall_d = stall_q;
    if (flush) begin
      stall_d = '0;
    end else if (out_valid_w && (!bus.out_ready || freeze) && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed table-driven bench for if_id_skid_reg plus hand sequences for reset and counter saturation.
module tb_if_id_skid_reg;

`ifdef IF_ID_STALL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;
  logic freeze;
  logic flush;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;
  logic freeze2;
  logic flush2;

  if_id_skid_reg_if #(.PC_W(32), .INSTR_W(32)) b1 ();
  if_id_skid_reg_if #(.PC_W(32), .INSTR_W(32)) b2 ();

  if_id_skid_reg #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .bus(b1), .stall_cnt(stall_cnt)
  );

  if_id_skid_reg #(.PC_W(32), .INSTR_W(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .freeze(freeze2), .flush(flush2), .bus(b2), .stall_cnt(stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass;
  int unsigned n_tot;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic        fz;
    logic        fl;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        ordy;
    logic        ov;
    logic [31:0] opc;
    logic [31:0] oins;
    logic        ir;
    int unsigned sc;
  } vec_t;

  function automatic vec_t mk(input logic fz, input logic fl, input logic iv, input logic [31:0] pc,
                              input logic [31:0] ins, input logic ordy, input logic ov,
                              input logic [31:0] opc, input logic [31:0] oins, input logic ir,
                              input int unsigned sc);
    vec_t v;
    v.fz = fz; v.fl = fl; v.iv = iv; v.pc = pc; v.ins = ins; v.ordy = ordy;
    v.ov = ov; v.opc = opc; v.oins = oins; v.ir = ir; v.sc = sc;
    return v;
  endfunction

  vec_t vecs[19];
  int unsigned sat_exp[6];

  initial begin
    n_pass = 0;
    n_tot  = 0;
    //             fz fl iv pc     ins            ordy ov opc    oins           ir sc
    vecs[0]  = mk(0, 0, 0, 32'h0,  32'h0,         1,   0, 32'h0,  NOP,          1, 0);
    vecs[1]  = mk(0, 0, 1, 32'h4,  32'h12345678,  1,   1, 32'h4,  32'h12345678, 1, 0);
    vecs[2]  = mk(0, 0, 0, 32'h0,  32'h0,         1,   0, 32'h0,  NOP,          1, 0);
    vecs[3]  = mk(0, 0, 1, 32'h8,  32'hA8,        0,   1, 32'h8,  32'hA8,       1, 0);
    vecs[4]  = mk(0, 0, 1, 32'hC,  32'hAC,        0,   1, 32'h8,  32'hA8,       0, 1);
    vecs[5]  = mk(0, 0, 1, 32'h10, 32'hB0,        0,   1, 32'h8,  32'hA8,       0, 2);
    vecs[6]  = mk(0, 0, 1, 32'h10, 32'hB0,        1,   1, 32'hC,  32'hAC,       1, 2);
    vecs[7]  = mk(0, 0, 1, 32'h10, 32'hB0,        1,   1, 32'h10, 32'hB0,       1, 2);
    vecs[8]  = mk(0, 0, 0, 32'h0,  32'h0,         1,   0, 32'h0,  NOP,          1, 2);
    vecs[9]  = mk(0, 1, 0, 32'h0,  32'h0,         1,   0, 32'h0,  NOP,          1, 0);
    vecs[10] = mk(0, 0, 1, 32'h20, 32'hC0,        0,   1, 32'h20, 32'hC0,       1, 0);
    vecs[11] = mk(1, 0, 1, 32'h24, 32'hC4,        1,   1, 32'h20, 32'hC0,       0, 1);
    vecs[12] = mk(1, 0, 1, 32'h24, 32'hC4,        1,   1, 32'h20, 32'hC0,       0, 2);
    vecs[13] = mk(1, 0, 1, 32'h24, 32'hC4,        1,   1, 32'h20, 32'hC0,       0, 3);
    vecs[14] = mk(0, 0, 0, 32'h0,  32'h0,         1,   0, 32'h0,  NOP,          1, 3);
    vecs[15] = mk(0, 0, 1, 32'h30, 32'hD0,        0,   1, 32'h30, 32'hD0,       1, 3);
    vecs[16] = mk(0, 0, 1, 32'h34, 32'hD4,        0,   1, 32'h30, 32'hD0,       0, 4);
    vecs[17] = mk(1, 1, 1, 32'h38, 32'hD8,        0,   0, 32'h0,  NOP,          0, 0);
    vecs[18] = mk(0, 0, 0, 32'h0,  32'h0,         0,   0, 32'h0,  NOP,          1, 0);
    sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3;
    sat_exp[3] = 3; sat_exp[4] = 3; sat_exp[5] = 3;

    rst_n = 1'b1; freeze = 1'b0; flush = 1'b0;
    b1.in_valid = 1'b0; b1.in_pc = '0; b1.in_instr = '0; b1.out_ready = 1'b0;
    freeze2 = 1'b0; flush2 = 1'b0;
    b2.in_valid = 1'b0; b2.in_pc = '0; b2.in_instr = '0; b2.out_ready = 1'b0;

    // Asynchronous reset visible before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst.out_valid", {63'd0, b1.out_valid}, 64'd0);
    chk("rst.out_pc", {32'd0, b1.out_pc}, 64'd0);
    chk("rst.out_instr", {32'd0, b1.out_instr}, {32'd0, NOP});
    chk("rst.in_ready", {63'd0, b1.in_ready}, 64'd1);
    chk("rst.stall_cnt", {48'd0, stall_cnt}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      freeze = vecs[i].fz; flush = vecs[i].fl;
      b1.in_valid = vecs[i].iv; b1.in_pc = vecs[i].pc; b1.in_instr = vecs[i].ins;
      b1.out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.out_valid", i), {63'd0, b1.out_valid}, {63'd0, vecs[i].ov});
      chk($sformatf("v%0d.out_pc", i), {32'd0, b1.out_pc}, {32'd0, vecs[i].opc});
      chk($sformatf("v%0d.out_instr", i), {32'd0, b1.out_instr}, {32'd0, vecs[i].oins});
      chk($sformatf("v%0d.in_ready", i), {63'd0, b1.in_ready}, {63'd0, vecs[i].ir});
      chk($sformatf("v%0d.stall_cnt", i), {48'd0, stall_cnt}, STATS ? 64'(vecs[i].sc) : 64'd0);
    end

    // Fill to TWO, then pulse reset between edges
    @(negedge clk);
    freeze = 1'b0; flush = 1'b0;
    b1.in_valid = 1'b1; b1.in_pc = 32'h50; b1.in_instr = 32'hE0; b1.out_ready = 1'b0;
    @(negedge clk);
    b1.in_pc = 32'h54; b1.in_instr = 32'hE4;
    @(posedge clk);
    #1;
    chk("two.in_ready", {63'd0, b1.in_ready}, 64'd0);
    chk("two.out_pc", {32'd0, b1.out_pc}, 64'h50);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst.out_valid", {63'd0, b1.out_valid}, 64'd0);
    chk("mid_rst.out_pc", {32'd0, b1.out_pc}, 64'd0);
    chk("mid_rst.out_instr", {32'd0, b1.out_instr}, {32'd0, NOP});
    chk("mid_rst.in_ready", {63'd0, b1.in_ready}, 64'd1);
    chk("mid_rst.stall_cnt", {48'd0, stall_cnt}, 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    b1.in_pc = 32'h60; b1.in_instr = 32'hF0; b1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst.out_valid", {63'd0, b1.out_valid}, 64'd1);
    chk("post_rst.out_pc", {32'd0, b1.out_pc}, 64'h60);
    chk("post_rst.out_instr", {32'd0, b1.out_instr}, 64'hF0);
    @(negedge clk);
    b1.in_valid = 1'b0;

    // Narrow counter saturation on the second instance
    @(negedge clk);
    b2.in_valid = 1'b1; b2.in_pc = 32'h70; b2.in_instr = 32'h77; b2.out_ready = 1'b0;
    @(negedge clk);
    b2.in_valid = 1'b0;
    chk("sat.out_valid", {63'd0, b2.out_valid}, 64'd1);
    chk("sat.out_instr", {32'd0, b2.out_instr}, 64'h77);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d.stall_cnt", k), {62'd0, stall_cnt2}, STATS ? 64'(sat_exp[k]) : 64'd0);
    end
    flush2 = 1'b1;
    @(posedge clk);
    #1;
    chk("sat.flush.stall_cnt", {62'd0, stall_cnt2}, 64'd0);
    chk("sat.flush.out_valid", {63'd0, b2.out_valid}, 64'd0);
    flush2 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
